// File: rtl/msgPass_config_pkg.sv
// Shared defaults, FSM state type and counter width for the message-pass buffer.
package msgPass_config_pkg;

    localparam int unsigned MSGPASS_BUFF_DATA_WIDTH = 8;
    localparam int unsigned MSGPASS_BUFF_DEPTH      = 64;
    localparam int unsigned MSGPASS_BUFF_ADDR_WIDTH = $clog2(MSGPASS_BUFF_DEPTH);
    localparam int unsigned MSGPASS_BUFF_NUM_WR     = 2;
    localparam int unsigned MSGPASS_BUFF_NUM_RD     = 2;
    localparam int unsigned MSGPASS_BUFF_CNT_WIDTH  = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } msgpass_buff_state_e;

endpackage

// File: rtl/msgpass_buffer_mp_if.sv
// Read/write/conflict bundle between the permutation network side and the buffer.
interface msgpass_buffer_mp_if
    import msgPass_config_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MSGPASS_BUFF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = MSGPASS_BUFF_ADDR_WIDTH,
    parameter int unsigned NUM_WR     = MSGPASS_BUFF_NUM_WR,
    parameter int unsigned NUM_RD     = MSGPASS_BUFF_NUM_RD,
    parameter int unsigned CNT_WIDTH  = MSGPASS_BUFF_CNT_WIDTH
);
    logic                           ready_o;
    logic [NUM_WR-1:0]              wen_i;
    logic [NUM_WR*ADDR_WIDTH-1:0]   waddr_i;
    logic [NUM_WR*DATA_WIDTH-1:0]   wdata_i;
    logic [NUM_RD-1:0]              ren_i;
    logic [NUM_RD*ADDR_WIDTH-1:0]   raddr_i;
    logic [NUM_RD*DATA_WIDTH-1:0]   rdata_o;
    logic [NUM_RD-1:0]              rvalid_o;
    logic                           wr_conflict_o;
    logic                           conflict_sticky_o;
    logic                           conflict_clr_i;
    logic [CNT_WIDTH-1:0]           conflict_cnt_o;

    modport master (
        output wen_i, waddr_i, wdata_i, ren_i, raddr_i, conflict_clr_i,
        input  ready_o, rdata_o, rvalid_o, wr_conflict_o, conflict_sticky_o, conflict_cnt_o
    );

    modport slave (
        input  wen_i, waddr_i, wdata_i, ren_i, raddr_i, conflict_clr_i,
        output ready_o, rdata_o, rvalid_o, wr_conflict_o, conflict_sticky_o, conflict_cnt_o
    );

endinterface

// File: rtl/msgpass_wr_arbiter.sv
// Per-port write winner mask (highest enabled index wins per address) and collision flag.
module msgpass_wr_arbiter #(
    parameter int unsigned NUM_WR     = 2,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic [NUM_WR-1:0]            wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    output logic [NUM_WR-1:0]            win_c,
    output logic                         conflict_c
);

    // A port loses if any higher-index enabled port targets the same address.
    always_comb begin
        win_c = wen;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            for (int q = p + 1; q < int'(NUM_WR); q++) begin
                if (wen[q] && (waddr[q*ADDR_WIDTH +: ADDR_WIDTH] == waddr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    win_c[p] = 1'b0;
                end
            end
        end
        conflict_c = |(wen & ~win_c);
    end

endmodule

// File: rtl/msgpass_buffer_mp.sv
// Multi-port LDPC message buffer with post-reset clear, write arbitration and conflict stats.
// Define MSGPASS_BUFF_BYPASS_EN to forward same-cycle write data to reads.
module msgpass_buffer_mp
    import msgPass_config_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MSGPASS_BUFF_DATA_WIDTH,
    parameter int unsigned DEPTH      = MSGPASS_BUFF_DEPTH,
    parameter int unsigned NUM_WR     = MSGPASS_BUFF_NUM_WR,
    parameter int unsigned NUM_RD     = MSGPASS_BUFF_NUM_RD,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned CNT_WIDTH  = MSGPASS_BUFF_CNT_WIDTH
) (
    input logic                clk_i,
    input logic                rst_i,
    msgpass_buffer_mp_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

    msgpass_buff_state_e          state_q, state_n;
    logic [ADDR_WIDTH-1:0]        ptr_q, ptr_n;
    logic                         ready_q;
    logic [DATA_WIDTH-1:0]        mem [DEPTH];
    logic [NUM_WR-1:0]            win_c;
    logic                         conflict_c;
    logic [DATA_WIDTH-1:0]        rd_word_c [NUM_RD];
    logic [NUM_RD*DATA_WIDTH-1:0] rdata_q;
    logic [NUM_RD-1:0]            rvalid_q;
    logic                         wr_conflict_q;
    logic                         sticky_q;
    logic [CNT_WIDTH-1:0]         cnt_q;
    logic                         active;

    assign active = (state_q == READY);

    msgpass_wr_arbiter #(
        .NUM_WR     (NUM_WR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arb (
        .wen        (bus.wen_i),
        .waddr      (bus.waddr_i),
        .win_c      (win_c),
        .conflict_c (conflict_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_n;
            ptr_q   <= ptr_n;
            ready_q <= (state_n == READY);
        end
    end

    // Clear walks every address once, then the buffer stays ready until reset.
    always_comb begin
        state_n = state_q;
        ptr_n   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_n = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_n = READY;
                end
            end
            READY:   state_n = READY;
            default: state_n = CLEAR;
        endcase
    end

    // Winners have distinct addresses, so loop order does not matter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                mem[ptr_q] <= '0;
            end else begin
                for (int p = 0; p < int'(NUM_WR); p++) begin
                    if (win_c[p]) begin
                        mem[bus.waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < int'(NUM_RD); r++) begin
            rd_word_c[r] = mem[bus.raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef MSGPASS_BUFF_BYPASS_EN
            for (int p = 0; p < int'(NUM_WR); p++) begin
                if (win_c[p] && (bus.waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == bus.raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rd_word_c[r] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else if (active) begin
            rvalid_q <= bus.ren_i;
            for (int r = 0; r < int'(NUM_RD); r++) begin
                if (bus.ren_i[r]) begin
                    rdata_q[r*DATA_WIDTH +: DATA_WIDTH] <= rd_word_c[r];
                end
            end
        end else begin
            rvalid_q <= '0;
        end
    end

    // A coincident clear beats a new conflict for sticky/count; the pulse still fires.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_conflict_q <= 1'b0;
            sticky_q      <= 1'b0;
            cnt_q         <= '0;
        end else begin
            wr_conflict_q <= active && conflict_c;
            if (bus.conflict_clr_i) begin
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end else if (active && conflict_c) begin
                sticky_q <= 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign bus.ready_o           = ready_q;
    assign bus.rdata_o           = rdata_q;
    assign bus.rvalid_o          = rvalid_q;
    assign bus.wr_conflict_o     = wr_conflict_q;
    assign bus.conflict_sticky_o = sticky_q;
    assign bus.conflict_cnt_o    = cnt_q;

endmodule
